// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high segment patterns (a..g = bit6..0)
// for the sixteen hex digits, the blank pattern, and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h7E;
  localparam logic [6:0] SEG7_1     = 7'h30;
  localparam logic [6:0] SEG7_2     = 7'h6D;
  localparam logic [6:0] SEG7_3     = 7'h79;
  localparam logic [6:0] SEG7_4     = 7'h33;
  localparam logic [6:0] SEG7_5     = 7'h5B;
  localparam logic [6:0] SEG7_6     = 7'h5F;
  localparam logic [6:0] SEG7_7     = 7'h70;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h7B;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h1F;
  localparam logic [6:0] SEG7_C     = 7'h4E;
  localparam logic [6:0] SEG7_D     = 7'h3D;
  localparam logic [6:0] SEG7_E     = 7'h4F;
  localparam logic [6:0] SEG7_F     = 7'h47;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  // Element i holds the pattern that displays hex digit i.
  localparam logic [15:0][6:0] SEG7_CODES = {
    SEG7_F, SEG7_E, SEG7_D, SEG7_C, SEG7_B, SEG7_A, SEG7_9, SEG7_8,
    SEG7_7, SEG7_6, SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } seg7_state_t;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Frame output port of the seven-segment capture block: a decoded frame
// offered on a valid/ready handshake plus a dropped-frame pulse.
interface seven_seg_capture_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] out_value;
  logic [NUM_DIGITS-1:0]   out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;

  modport master (
    output out_value,
    output out_err,
    output out_valid,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_value,
    input  out_err,
    input  out_valid,
    input  overrun,
    output out_ready
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex-to-seven-segment table. Unknown patterns,
// including a blank digit, decode to zero with the error flag raised.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  // Search the shared code table for the pattern being displayed.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG7_CODES[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed active-low seven-segment display bus, decodes every
// digit that dwells long enough, and delivers complete frames on a
// valid/ready port. Frames that complete while the port is still occupied
// are dropped and flagged with a one-cycle overrun pulse.
module seven_seg_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] an_n,
  seven_seg_capture_if.master   out_if
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LOW_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]            seg_s1_q, seg_s2_q, seg_p_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_p_q;

  logic [CNT_W-1:0]      stab_cnt_q, stab_cnt_d;
  seg7_state_t           state_q, state_d;

  logic [NUM_DIGITS-1:0][3:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]      shadow_err_q, shadow_err_d;
  logic [NUM_DIGITS-1:0]      mask_q, mask_d;

  logic [NUM_DIGITS-1:0][3:0] out_value_q, out_value_d;
  logic [NUM_DIGITS-1:0]      out_err_q, out_err_d;
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;

  logic [LOW_W-1:0] low_cnt;
  logic [IDX_W-1:0] low_idx;
  logic             one_hot;
  logic             same;
  logic             stable;
  logic             do_sample;
  logic [3:0]       dec_nibble;
  logic             dec_err;
  logic             frame_done;
  logic             accept;

  seg7_decode u_decode (
    .pattern (~seg_s2_q),
    .nibble  (dec_nibble),
    .err     (dec_err)
  );

  // Count the active anodes and remember which one is lit.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        low_cnt = low_cnt + LOW_W'(1);
        low_idx = IDX_W'(i);
      end
    end
  end

  assign one_hot = (low_cnt == LOW_W'(1));
  assign same    = ({an_s2_q, seg_s2_q} == {an_p_q, seg_p_q});
  assign stable  = same && one_hot;

  // Dwell counter and the idle/settle/hold sequencing that allows one sample per dwell.
  always_comb begin
    stab_cnt_d = '0;
    if (stable) begin
      stab_cnt_d = (stab_cnt_q == CNT_MAX) ? stab_cnt_q : stab_cnt_q + CNT_W'(1);
    end
    state_d   = state_q;
    do_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!stable) begin
          state_d = IDLE;
        end else if (stab_cnt_d >= CNT_FIRE) begin
          do_sample = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!same) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow frame assembly, frame hand-off to the output register and the handshake.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_err_d = shadow_err_q;
    mask_d       = mask_q;
    out_value_d  = out_value_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;
    accept       = out_valid_q && out_if.out_ready;

    if (do_sample) begin
      shadow_val_d[low_idx] = dec_nibble;
      shadow_err_d[low_idx] = dec_err;
      mask_d[low_idx]       = 1'b1;
      if (&mask_d) begin
        frame_done = 1'b1;
        mask_d     = '0;
      end
    end

    if (frame_done) begin
      if (!out_valid_q || out_if.out_ready) begin
        out_value_d = shadow_val_d;
        out_err_d   = shadow_err_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // Synchronisers plus all state registers; reset discards any partial or held frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      seg_p_q      <= '0;
      an_s1_q      <= '0;
      an_s2_q      <= '0;
      an_p_q       <= '0;
      stab_cnt_q   <= '0;
      state_q      <= IDLE;
      shadow_val_q <= '0;
      shadow_err_q <= '0;
      mask_q       <= '0;
      out_value_q  <= '0;
      out_err_q    <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      seg_s1_q     <= seg_n;
      seg_s2_q     <= seg_s1_q;
      seg_p_q      <= seg_s2_q;
      an_s1_q      <= an_n;
      an_s2_q      <= an_s1_q;
      an_p_q       <= an_s2_q;
      stab_cnt_q   <= stab_cnt_d;
      state_q      <= state_d;
      shadow_val_q <= shadow_val_d;
      shadow_err_q <= shadow_err_d;
      mask_q       <= mask_d;
      out_value_q  <= out_value_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_if.out_value = out_value_q;
  assign out_if.out_err   = out_err_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: table-driven frames, hand-written corner
// sequences, and a randomized dwell stream checked against a dwell-level model.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int SC = 8;

  // Active-high patterns for hex digits 0..F, written out independently of the design.
  localparam logic [6:0] CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  err;
  } frame_t;

  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0]     exp_value;
    logic [3:0]      exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_n = 7'h7F;
  logic [ND-1:0] an_n = '1;

  int n_checks = 0;
  int n_fail   = 0;
  int overrun_seen = 0;
  frame_t got_q[$];
  frame_t exp_q[$];
  frame_t mon_f;

  seven_seg_capture_if #(.NUM_DIGITS(ND)) dut_if ();

  seven_seg_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .out_if (dut_if)
  );

  always #5 clk = ~clk;

  // Record every accepted frame and every overrun pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && dut_if.out_valid && dut_if.out_ready) begin
      mon_f.value = dut_if.out_value;
      mon_f.err   = dut_if.out_err;
      got_q.push_back(mon_f);
    end
    if (!rst && dut_if.overrun) overrun_seen++;
  end

  function automatic logic [6:0] seg_of(input int n);
    return ~CODES[n];
  endfunction

  function automatic int zeros(input logic [3:0] a);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) c++;
    return c;
  endfunction

  function automatic int low_index(input logic [3:0] a);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [4:0] decode_ref(input logic [6:0] seg);
    logic [6:0] p;
    p = ~seg;
    for (int i = 0; i < 16; i++) if (p == CODES[i]) return {1'b0, 4'(i)};
    return 5'b1_0000;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int len);
    an_n  = an;
    seg_n = seg;
    tick(len);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_frame(input logic [3:0][6:0] segs, input int len);
    logic [3:0] an;
    for (int d = 0; d < 4; d++) begin
      an = ~(4'b0001 << d);
      applyStimulus(an, segs[d], len);
    end
  endtask

  vec_t vecs [5];
  logic [3:0] r_an, prev_an;
  logic [6:0] r_seg, prev_seg;
  int r_len, r_kind, r_ci, r_d, ov_base, n_cmp;
  bit r_rdy, m_valid, all_done;
  frame_t m_held;
  logic [3:0] m_val [4];
  logic m_err [4];
  bit m_done [4];
  int m_overruns;
  logic [4:0] dec;

  initial begin
    dut_if.out_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    tick(3);
    checkOutput("reset_valid", 32'(dut_if.out_valid), 32'd0);
    checkOutput("reset_value", 32'(dut_if.out_value), 32'd0);
    checkOutput("reset_err", 32'(dut_if.out_err), 32'd0);
    checkOutput("reset_overrun", 32'(dut_if.overrun), 32'd0);
    rst = 1'b0;
    tick(2);

    // Full frames with expected decoded value and error flags.
    vecs[0] = '{segs: {7'b0111000, 7'b0000000, 7'b0000001, 7'b0000110}, exp_value: 16'hF803, exp_err: 4'b0000};
    vecs[1] = '{segs: {7'b1001100, 7'b1111111, 7'b0010010, 7'b1001111}, exp_value: 16'h4021, exp_err: 4'b0100};
    vecs[2] = '{segs: {7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000}, exp_value: 16'hDCBA, exp_err: 4'b0000};
    vecs[3] = '{segs: {7'b0001111, 7'b0100000, 7'b0100100, 7'b0110000}, exp_value: 16'h765E, exp_err: 4'b0000};
    vecs[4] = '{segs: {7'b0000110, 7'b1111110, 7'b0101010, 7'b0000100}, exp_value: 16'h3009, exp_err: 4'b0110};
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      send_frame(vecs[v].segs, 12);
      tick(4);
      checkOutput($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_value", v), 32'(got_q[0].value), 32'(vecs[v].exp_value));
        checkOutput($sformatf("vec%0d_err", v), 32'(got_q[0].err), 32'(vecs[v].exp_err));
      end
    end

    // Short dwell and glitched dwell on digit 0 never capture it.
    got_q.delete();
    applyStimulus(4'b1110, seg_of(1), SC - 1);
    applyStimulus(4'b1101, seg_of(2), 12);
    applyStimulus(4'b1011, seg_of(4), 12);
    applyStimulus(4'b0111, seg_of(6), 12);
    tick(4);
    checkOutput("short_dwell_no_frame", 32'(got_q.size()), 32'd0);
    applyStimulus(4'b1110, seg_of(5), 5);
    applyStimulus(4'b1110, seg_of(3), 1);
    applyStimulus(4'b1110, seg_of(5), 5);
    applyStimulus(4'b1101, seg_of(7), 12);
    tick(4);
    checkOutput("glitch_no_frame", 32'(got_q.size()), 32'd0);
    applyStimulus(4'b1110, seg_of(5), 12);
    tick(4);
    checkOutput("dwell_frame_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("dwell_frame_value", 32'(got_q[0].value), 32'h6475);

    // Two anodes low: no sample, partial frame kept.
    got_q.delete();
    applyStimulus(4'b1110, seg_of(9), 12);
    applyStimulus(4'b1101, seg_of(10), 12);
    applyStimulus(4'b1100, seg_of(1), 20);
    checkOutput("multi_low_no_frame", 32'(got_q.size()), 32'd0);
    applyStimulus(4'b1011, seg_of(11), 12);
    applyStimulus(4'b0111, seg_of(12), 12);
    tick(4);
    checkOutput("multi_low_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("multi_low_value", 32'(got_q[0].value), 32'hCBA9);

    // Backpressure: second frame is dropped, first frame held.
    dut_if.out_ready = 1'b0;
    ov_base = overrun_seen;
    send_frame({seg_of(4), seg_of(3), seg_of(2), seg_of(1)}, 12);
    tick(4);
    checkOutput("bp_first_valid", 32'(dut_if.out_valid), 32'd1);
    checkOutput("bp_first_value", 32'(dut_if.out_value), 32'h4321);
    send_frame({seg_of(5), seg_of(6), seg_of(7), seg_of(8)}, 12);
    tick(4);
    checkOutput("bp_overrun_count", 32'(overrun_seen - ov_base), 32'd1);
    checkOutput("bp_held_value", 32'(dut_if.out_value), 32'h4321);
    checkOutput("bp_held_valid", 32'(dut_if.out_valid), 32'd1);
    got_q.delete();
    dut_if.out_ready = 1'b1;
    tick(1);
    checkOutput("bp_valid_dropped", 32'(dut_if.out_valid), 32'd0);
    checkOutput("bp_accept_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("bp_accept_value", 32'(got_q[0].value), 32'h4321);

    // Reset after three of four digits discards the partial frame.
    applyStimulus(4'b1110, seg_of(1), 12);
    applyStimulus(4'b1101, seg_of(2), 12);
    applyStimulus(4'b1011, seg_of(3), 12);
    rst = 1'b1;
    tick(2);
    checkOutput("midrst_valid", 32'(dut_if.out_valid), 32'd0);
    checkOutput("midrst_value", 32'(dut_if.out_value), 32'd0);
    checkOutput("midrst_err", 32'(dut_if.out_err), 32'd0);
    got_q.delete();
    an_n  = 4'b0111;
    seg_n = seg_of(14);
    rst   = 1'b0;
    tick(12);
    applyStimulus(4'b1110, seg_of(7), 12);
    applyStimulus(4'b1101, seg_of(8), 12);
    applyStimulus(4'b1011, seg_of(9), 12);
    tick(4);
    checkOutput("postrst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("postrst_value", 32'(got_q[0] ), 32'({16'hE987, 4'h0}));

    // Randomized dwell stream against the dwell-level model.
    got_q.delete();
    exp_q.delete();
    ov_base    = overrun_seen;
    m_overruns = 0;
    m_valid    = 1'b0;
    for (int d = 0; d < 4; d++) m_done[d] = 1'b0;
    prev_an  = an_n;
    prev_seg = seg_n;
    for (int k = 0; k < 80; k++) begin
      do begin
        r_kind = int'($urandom_range(0, 9));
        if (r_kind < 8) begin
          r_d   = int'($urandom_range(0, 3));
          r_an  = ~(4'b0001 << r_d);
          r_len = (r_kind < 6) ? int'($urandom_range(12, 16)) : int'($urandom_range(1, SC - 1));
        end else begin
          do r_an = 4'($urandom); while (zeros(r_an) == 1);
          r_len = int'($urandom_range(1, 16));
        end
        r_ci  = int'($urandom_range(0, 15));
        r_seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : seg_of(r_ci);
      end while ({r_an, r_seg} == {prev_an, prev_seg});
      r_rdy = ($urandom_range(0, 2) != 0);

      if (m_valid && r_rdy) begin
        exp_q.push_back(m_held);
        m_valid = 1'b0;
      end
      if (zeros(r_an) == 1 && r_len >= SC) begin
        r_d       = low_index(r_an);
        dec       = decode_ref(r_seg);
        m_val[r_d]  = dec[3:0];
        m_err[r_d]  = dec[4];
        m_done[r_d] = 1'b1;
        all_done = 1'b1;
        for (int d = 0; d < 4; d++) all_done = all_done && m_done[d];
        if (all_done) begin
          for (int d = 0; d < 4; d++) m_done[d] = 1'b0;
          if (!m_valid || r_rdy) begin
            m_held.value = '0;
            m_held.err   = '0;
            for (int d = 0; d < 4; d++) begin
              m_held.value = m_held.value | (16'(m_val[d]) << (4 * d));
              m_held.err[d] = m_err[d];
            end
            if (r_rdy) exp_q.push_back(m_held);
            else m_valid = 1'b1;
          end else begin
            m_overruns++;
          end
        end
      end

      dut_if.out_ready = r_rdy;
      applyStimulus(r_an, r_seg, r_len);
      prev_an  = r_an;
      prev_seg = r_seg;
    end
    dut_if.out_ready = 1'b1;
    if (m_valid) exp_q.push_back(m_held);
    applyStimulus(4'b1111, 7'h7F, 6);

    checkOutput("rand_frame_count", 32'(got_q.size()), 32'(exp_q.size()));
    checkOutput("rand_overruns", 32'(overrun_seen - ov_base), 32'(m_overruns));
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      checkOutput($sformatf("rand_frame%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
